cmp_scheduler: RTL and testbench
================================

CMP_SCHEDULER -- requirements
Module: cmp_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one approximate comparator core (fixed at 4 in this revision).
REQ-002 Parameter W, default 3, operand width of each core input.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester job valid.
REQ-006 req_ops  input  NREQ*4*W  per-requester bundle {d,c,b,a}; requester i occupies bits [12i+11:12i], with a in the low W bits.
REQ-007 req_ready  output  NREQ  one-hot grant/accept strobe.
REQ-008 core_a, core_b, core_c, core_d  output  W each  operands driven to the external combinational comparator core.
REQ-009 core_out  input  1  comparator decision, (a+b) versus (c+d), approximate.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer accepts result.
REQ-012 res_bit  output  1  captured core_out.
REQ-013 res_tag  output  2  index of the requester that owns the result.
REQ-014 cnt_clr  input  1  synchronous clear of all hit counters.
REQ-015 hit_cnt  output  NREQ*8  per-requester count of accepted results with res_bit=1; requester i occupies bits [8i+7:8i].
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, EVAL and OUT.
REQ-018 IDLE: if any req_valid is high, the block SHALL grant one requester by round-robin, pulse its req_ready for exactly that cycle, register its four operands into core_a..core_d and the requester index into res_tag, then go to EVAL; otherwise it SHALL stay in IDLE.
REQ-019 Round-robin SHALL search from (last_grant+1) mod NREQ upward with wrap-around, and last_grant SHALL update only on a grant.
REQ-020 req_ready SHALL be all-zero in EVAL and OUT; req_valid in those states SHALL be ignored and left pending.
REQ-021 EVAL: core_a..core_d SHALL hold the registered operands, core_out SHALL be captured into res_bit at the end of the cycle, and the FSM SHALL go to OUT.
REQ-022 OUT: res_valid SHALL be 1 while res_bit and res_tag are held stable; on res_valid&&res_ready the FSM SHALL go to IDLE, otherwise stay in OUT indefinitely.
REQ-023 Latency: res_valid SHALL assert 2 cycles after the accept cycle, and the minimum spacing between grants SHALL be 3 cycles.
REQ-024 core_a..core_d SHALL keep their last loaded values outside EVAL and SHALL change only on a grant.
REQ-025 On each result handshake with res_bit=1, hit_cnt[res_tag] SHALL increment by 1, saturating at 255 with no wrap.
REQ-026 cnt_clr SHALL zero all counters the next cycle and SHALL win over a simultaneous increment; it SHALL NOT affect the FSM.
REQ-027 busy SHALL equal (state != IDLE).

Reset
REQ-028 With rst high, the block SHALL enter IDLE, set last_grant=NREQ-1 so requester 0 has first priority, and zero res_valid, res_bit, res_tag, req_ready, core_a..core_d, busy and all hit_cnt.
REQ-029 Reset in EVAL or OUT SHALL discard the in-flight job without a result handshake and without a counter update; reset SHALL take priority over all other inputs.

Verification
REQ-030 Single job: req_valid=0001, ops a=3, b=2, c=1, d=0, core model returns 1, res_ready=1 -> req_ready=0001 at cycle 0, core_a=3 in cycle 1, res_valid=1, res_bit=1, res_tag=0 at cycle 2, hit_cnt[0]=1.
REQ-031 Contention: req_valid=1111 held for 4 jobs with res_ready=1 -> grant order 0,1,2,3, grants at cycles 0,3,6,9.
REQ-032 Backpressure: res_ready=0 for 5 cycles in OUT -> res_valid, res_bit and res_tag stable, no new req_ready; on res_ready=1 -> IDLE the next cycle.
REQ-033 Saturation/clear: 260 accepted results with res_bit=1 on requester 2 -> hit_cnt[2]=255; cnt_clr asserted in the same cycle as an increment -> hit_cnt[2]=0.
REQ-034 Reset mid-operation: rst in EVAL -> next cycle IDLE, res_valid=0, counters 0, and next grant goes to requester 0.

Source files
------------

// File: rtl/cmp_scheduler.sv
// ---------------------------------------------------------------------------
// cmp_scheduler
//   Shares one external combinational comparator core, (a+b) vs (c+d), among
//   NREQ requesters. The requester is picked by round-robin in IDLE, its
//   operands are evaluated in EVAL, and the result is held in OUT until the
//   consumer accepts it. Each requester has a saturating 8-bit count of the
//   results it has had accepted with res_bit=1.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/ready    : per-requester job handshake (ready is a one-hot grant)
//   req_ops            : per-requester {d,c,b,a}, W bits each
//   core_a..core_d     : registered operands driven to the comparator core
//   core_out           : comparator decision, captured in EVAL
//   res_valid/ready    : result handshake; res_bit = decision, res_tag = owner
//   cnt_clr            : synchronous clear of all hit counters
//   hit_cnt            : per-requester hit counters, 8 bits each
//   busy               : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module cmp_scheduler #(
   parameter int NREQ = 4,
   parameter int W    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*4*W-1:0]   req_ops,
   output logic [NREQ-1:0]       req_ready,
   output logic [W-1:0]          core_a,
   output logic [W-1:0]          core_b,
   output logic [W-1:0]          core_c,
   output logic [W-1:0]          core_d,
   input  logic                  core_out,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic                  res_bit,
   output logic [1:0]            res_tag,
   input  logic                  cnt_clr,
   output logic [NREQ*8-1:0]     hit_cnt,
   output logic                  busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EVAL = 2'd1;
   localparam logic [1:0] OUT  = 2'd2;

   logic [1:0]            state;
   logic [1:0]            last_grant;
   logic [1:0]            gnt_idx;
   logic [1:0]            cand;
   logic                  gnt_any;
   logic                  grant;
   logic [4*W-1:0]        sel_ops;
   logic [NREQ-1:0][7:0]  cnt;

   // Round-robin: scan last_grant+1 .. last_grant+NREQ; the 2-bit index wraps
   // modulo 4, which matches NREQ in this revision.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = last_grant;
      cand    = last_grant;
      for (int k = 1; k <= NREQ; k++) begin
         cand = last_grant + 2'(k);
         if (!gnt_any && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      sel_ops = '0;
      for (int i = 0; i < NREQ; i++)
         if (gnt_idx == 2'(i)) sel_ops = req_ops[i*4*W +: 4*W];
   end

   // Grant only from IDLE and never while reset is asserted.
   assign grant     = (state == IDLE) && gnt_any && !rst;
   assign req_ready = grant ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
   assign res_valid = (state == OUT);
   assign busy      = (state != IDLE);
   assign hit_cnt   = cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 2'(NREQ-1);
         core_a     <= '0;
         core_b     <= '0;
         core_c     <= '0;
         core_d     <= '0;
         res_bit    <= 1'b0;
         res_tag    <= 2'd0;
      end else begin
         case (state)
            IDLE: if (grant) begin
               last_grant <= gnt_idx;
               res_tag    <= gnt_idx;
               core_a     <= sel_ops[0*W +: W];
               core_b     <= sel_ops[1*W +: W];
               core_c     <= sel_ops[2*W +: W];
               core_d     <= sel_ops[3*W +: W];
               state      <= EVAL;
            end
            EVAL: begin
               res_bit <= core_out;
               state   <= OUT;
            end
            OUT: if (res_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Clear beats a same-cycle increment; counters stop at 255.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr)
         cnt <= '0;
      else if (res_valid && res_ready && res_bit && cnt[res_tag] != 8'hFF)
         cnt[res_tag] <= cnt[res_tag] + 8'd1;
   end

endmodule

// File: tb/tb_cmp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cmp_scheduler
//   Directed bench for cmp_scheduler. The comparator core is modelled as an
//   exact (a+b) > (c+d); expected values below are hand-derived from that.
// ---------------------------------------------------------------------------
module tb_cmp_scheduler;

   localparam int NREQ = 4;
   localparam int W    = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*4*W-1:0]  req_ops;
   logic [NREQ-1:0]      req_ready;
   logic [W-1:0]         core_a, core_b, core_c, core_d;
   logic                 core_out;
   logic                 res_valid;
   logic                 res_ready;
   logic                 res_bit;
   logic [1:0]           res_tag;
   logic                 cnt_clr;
   logic [NREQ*8-1:0]    hit_cnt;
   logic                 busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign core_out = ({1'b0, core_a} + {1'b0, core_b}) > ({1'b0, core_c} + {1'b0, core_d});

   cmp_scheduler #(.NREQ(NREQ), .W(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ops(req_ops),
      .req_ready(req_ready), .core_a(core_a), .core_b(core_b),
      .core_c(core_c), .core_d(core_d), .core_out(core_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_bit(res_bit),
      .res_tag(res_tag), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input int a, input int b, input int c, input int d);
      req_ops[i*12 +: 12] = {3'(d), 3'(c), 3'(b), 3'(a)};
   endtask

   function automatic logic [7:0] hc(input int i);
      return hit_cnt[i*8 +: 8];
   endfunction

   initial begin
      rst = 1'b1; req_valid = 4'b1111; req_ops = '0;
      res_ready = 1'b1; cnt_clr = 1'b0;

      // ---- reset state (req_valid high must not grant under reset)
      tick(); tick();
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_valid", 32'(res_valid), 32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_core",  32'({core_a, core_b, core_c, core_d}), 32'h0);
      chk("rst_tag",   32'(res_tag), 32'h0);
      chk("rst_bit",   32'(res_bit), 32'h0);
      chk("rst_hits",  hit_cnt, 32'h0);

      // ---- single job on requester 0: 3+2 > 1+0 -> 1
      rst = 1'b0; req_valid = 4'b0001; set_op(0, 3, 2, 1, 0);
      #1;
      chk("s_c0_ready", 32'(req_ready), 32'h1);
      tick(); req_valid = 4'b0000; #1;
      chk("s_c1_core_a", 32'(core_a), 32'd3);
      chk("s_c1_busy",   32'(busy), 32'h1);
      chk("s_c1_valid",  32'(res_valid), 32'h0);
      tick();
      chk("s_c2_valid", 32'(res_valid), 32'h1);
      chk("s_c2_bit",   32'(res_bit), 32'h1);
      chk("s_c2_tag",   32'(res_tag), 32'h0);
      tick();
      chk("s_c3_busy", 32'(busy), 32'h0);
      chk("s_hit0",    32'(hc(0)), 32'd1);

      // ---- contention after a fresh reset: grants 0,1,2,3 at cycles 0,3,6,9
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_op(i, i, 0, 1, 0);
      req_valid = 4'b1111;
      for (int k = 0; k < 12; k++) begin
         #1;
         chk($sformatf("ct_ready_%0d", k), 32'(req_ready),
             (k % 3 == 0) ? (32'h1 << (k / 3)) : 32'h0);
         if (k % 3 == 2) begin
            chk($sformatf("ct_tag_%0d", k), 32'(res_tag), 32'(k / 3));
            chk($sformatf("ct_bit_%0d", k), 32'(res_bit), (k / 3 > 1) ? 32'h1 : 32'h0);
         end
         tick();
      end
      req_valid = 4'b0000; #1;
      chk("ct_hits", hit_cnt, 32'h01010000);

      // ---- backpressure: job on 2 (2>1 -> 1), requester 0 left pending
      req_valid = 4'b0100; set_op(2, 2, 0, 1, 0); set_op(0, 0, 0, 1, 0);
      res_ready = 1'b0; #1;
      chk("bp_grant", 32'(req_ready), 32'h4);
      tick(); req_valid = 4'b0001; #1;
      chk("bp_eval_ready", 32'(req_ready), 32'h0);
      tick();
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp_hold_%0d", k),
             32'({res_valid, res_bit, res_tag, req_ready}), 32'({1'b1, 1'b1, 2'd2, 4'b0000}));
         tick();
      end
      res_ready = 1'b1; #1;
      chk("bp_rel_valid", 32'(res_valid), 32'h1);
      tick();
      chk("bp_idle_busy",  32'(busy), 32'h0);
      chk("bp_next_ready", 32'(req_ready), 32'h1);
      tick(); req_valid = 4'b0000; tick(); tick();
      chk("bp_hits", hit_cnt, 32'h01020000);

      // ---- saturation: 260 more hits on requester 2 (2 + 260 -> 255)
      req_valid = 4'b0100;
      for (int k = 0; k < 260 * 3; k++) tick();
      req_valid = 4'b0000; #1;
      chk("sat_hit2", 32'(hc(2)), 32'd255);
      chk("sat_busy", 32'(busy), 32'h0);

      // ---- clear coincident with an increment on requester 2
      req_valid = 4'b0100; tick(); req_valid = 4'b0000; tick();
      cnt_clr = 1'b1; #1;
      chk("clr_valid", 32'(res_valid), 32'h1);
      tick(); cnt_clr = 1'b0;
      chk("clr_hit2", 32'(hc(2)), 32'd0);
      chk("clr_busy", 32'(busy), 32'h0);

      // ---- one hit on requester 3 (3>1), then reset mid-EVAL on requester 1
      req_valid = 4'b1000; set_op(3, 3, 0, 1, 0); tick();
      req_valid = 4'b0000; tick(); tick();
      chk("r_hit3", 32'(hc(3)), 32'd1);
      req_valid = 4'b0010; set_op(1, 7, 7, 0, 0); #1;
      chk("r_grant1", 32'(req_ready), 32'h2);
      tick(); req_valid = 4'b0000;
      chk("r_eval_busy", 32'(busy), 32'h1);
      rst = 1'b1; tick(); rst = 1'b0; #1;
      chk("r_busy",  32'(busy), 32'h0);
      chk("r_valid", 32'(res_valid), 32'h0);
      chk("r_hits",  hit_cnt, 32'h0);
      req_valid = 4'b1111; #1;
      chk("r_first_grant", 32'(req_ready), 32'h1);
      req_valid = 4'b0000;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
